// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared constants for the multi-cycle CPU control unit: state codes,
// opcodes/functs, mux select codes and the control word layout.
package multi_cycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_MADDR = 4'd2,
    S_MRD   = 4'd3,
    S_MWB   = 4'd4,
    S_MWR   = 4'd5,
    S_REX   = 4'd6,
    S_RWB   = 4'd7,
    S_BR    = 4'd8,
    S_J     = 4'd9,
    S_JAL   = 4'd10,
    S_JR    = 4'd11,
    S_IEX   = 4'd12,
    S_IWB   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // Opcode/funct combinations the datapath knows how to execute.
  function automatic logic is_legal(input logic [5:0] opcode, input logic [5:0] funct);
    logic ok;
    ok = 1'b0;
    case (opcode)
      OP_RTYPE: ok = funct inside {FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_ADD, FN_ADDU,
                                   FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
                                   FN_SLT, FN_SLTU};
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LW, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output decode: current state (plus the held opcode) to control word.
// Only pc_en in the branch state looks at a live input (zero).
module mc_ctrl_decode
  import multi_cycle_ctrl_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic        zero,
  output ctrl_t       ctrl
);

  // Per-state datapath enables and mux selects; anything unlisted stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      S_IF: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_en     = 1'b1;
      end
      S_ID: ctrl.alu_src_b = SRCB_BROFF;
      S_MADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_MWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = MTR_MDR;
        ctrl.reg_dst    = REGDST_RT;
      end
      S_REX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = REGDST_RD;
      end
      S_IEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = (opcode == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
        ctrl.ext_zero  = (opcode == OP_ORI);
      end
      S_IWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = REGDST_RT;
      end
      S_BR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_source = PCSRC_ALUOUT;
        ctrl.pc_en     = (opcode == OP_BNE) ? ~zero : zero;
      end
      S_J: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_en     = 1'b1;
      end
      S_JAL: begin
        // Register file captures PC (return address) on the same edge PC loads.
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.pc_en      = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RA;
        ctrl.mem_to_reg = MTR_PC;
      end
      S_JR: begin
        ctrl.pc_source = PCSRC_REG;
        ctrl.pc_en     = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU main control: state register, next-state logic and the
// sticky illegal-instruction flag. Outputs are decoded from state only.
//
//  state | meaning
//  IF    | fetch, PC <- PC+4
//  ID    | decode, ALUOut <- branch target
//  MADDR | lw/sw address compute
//  MRD   | lw memory read
//  MWB   | lw write-back from MDR
//  MWR   | sw memory write
//  REX   | R-type execute
//  RWB   | R-type write-back to rd
//  BR    | beq/bne compare and conditional PC load
//  J     | jump
//  JAL   | jump and link to r31
//  JR    | jump register
//  IEX   | addi/ori execute
//  IWB   | addi/ori write-back to rt
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;
  logic   illegal_q;
  logic   insn_ok;
  ctrl_t  ctrl;

  assign insn_ok = is_legal(opcode, funct);

  // Next-state selection; decode dispatches on the IR held since fetch.
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:    state_d = S_ID;
      S_ID: begin
        if (!insn_ok) begin
          state_d = S_IF;
        end else begin
          case (opcode)
            OP_LW, OP_SW:    state_d = S_MADDR;
            OP_RTYPE:        state_d = (funct == FN_JR) ? S_JR : S_REX;
            OP_BEQ, OP_BNE:  state_d = S_BR;
            OP_J:            state_d = S_J;
            OP_JAL:          state_d = S_JAL;
            OP_ADDI, OP_ORI: state_d = S_IEX;
            default:         state_d = S_IF;
          endcase
        end
      end
      S_MADDR: state_d = (opcode == OP_LW) ? S_MRD : S_MWR;
      S_MRD:   state_d = S_MWB;
      S_REX:   state_d = S_RWB;
      S_IEX:   state_d = S_IWB;
      default: state_d = S_IF;
    endcase
  end

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IF;
    else        state_q <= state_d;
  end

  // Sticky illegal flag, raised when decode rejects the instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        illegal_q <= 1'b0;
    else if (state_q == S_ID && !insn_ok) illegal_q <= 1'b1;
  end

  mc_ctrl_decode u_decode (
    .state  (state_q),
    .opcode (opcode),
    .zero   (zero),
    .ctrl   (ctrl)
  );

  assign pc_en      = ctrl.pc_en;
  assign iord       = ctrl.iord;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_write  = ctrl.reg_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign ext_zero   = ctrl.ext_zero;
  assign alu_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;
  assign illegal    = illegal_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: each instruction pushes its expected
// per-cycle output words; every cycle one word is popped and compared.
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
  logic       alu_src_a, ext_zero, illegal;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;
  logic ill_exp = 1'b0;
  logic [22:0] exp_q[$];
  logic [22:0] obs_word;

  multi_cycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_zero(ext_zero), .alu_op(alu_op), .pc_source(pc_source),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  assign obs_word = {state, pc_en, iord, mem_read, mem_write, ir_write, reg_write,
                     reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_zero, alu_op,
                     pc_source, illegal};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Expected output word for one state, written from the control table.
  function automatic logic [22:0] exp_word(input logic [3:0] st, input logic [5:0] op,
                                           input logic z, input logic ill);
    logic pe = 0, io = 0, mr = 0, mw = 0, irw = 0, rw = 0, sa = 0, ez = 0;
    logic [1:0] rd = 0, mtr = 0, sb = 0, ao = 0, ps = 0;
    case (st)
      4'd0:  begin mr = 1; irw = 1; sb = 2'b01; pe = 1; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mr = 1; io = 1; end
      4'd4:  begin rw = 1; mtr = 2'b01; end
      4'd5:  begin mw = 1; io = 1; end
      4'd6:  begin sa = 1; ao = 2'b10; end
      4'd7:  begin rw = 1; rd = 2'b01; end
      4'd8:  begin sa = 1; ao = 2'b01; ps = 2'b01; pe = (op == 6'h05) ? !z : z; end
      4'd9:  begin ps = 2'b10; pe = 1; end
      4'd10: begin ps = 2'b10; pe = 1; rw = 1; rd = 2'b10; mtr = 2'b10; end
      4'd11: begin ps = 2'b11; pe = 1; end
      4'd12: begin sa = 1; sb = 2'b10; ao = (op == 6'h0D) ? 2'b11 : 2'b00; ez = (op == 6'h0D); end
      4'd13: rw = 1;
      default: ;
    endcase
    return {st, pe, io, mr, mw, irw, rw, rd, mtr, sa, sb, ez, ao, ps, ill};
  endfunction

  // Pushes the expected words for one instruction and checks ncyc cycles
  // of it (0 = the whole instruction, ending at the next fetch).
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int ncyc);
    logic [3:0] seq[$];
    logic bad;
    int n;
    bad = 1'b0;
    seq = '{4'd0, 4'd1};
    case (op)
      6'h23: seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      6'h2B: seq = '{4'd0, 4'd1, 4'd2, 4'd5};
      6'h04, 6'h05: seq.push_back(4'd8);
      6'h02: seq.push_back(4'd9);
      6'h03: seq.push_back(4'd10);
      6'h08, 6'h0D: seq = '{4'd0, 4'd1, 4'd12, 4'd13};
      6'h00: begin
        if (fn == 6'h08) seq.push_back(4'd11);
        else if (fn inside {6'h00, 6'h02, 6'h03, [6'h20:6'h27], 6'h2A, 6'h2B})
          seq = '{4'd0, 4'd1, 4'd6, 4'd7};
        else bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    foreach (seq[i]) exp_q.push_back(exp_word(seq[i], op, z, ill_exp));
    if (bad) ill_exp = 1'b1;
    n = (ncyc == 0) ? seq.size() : ncyc;
    opcode = op;
    funct  = fn;
    zero   = z;
    for (int i = 0; i < n; i++) begin
      #1;
      if (exp_q.size() == 0) check_eq({name, " queue_empty"}, 32'd1, 32'd0);
      else check_eq($sformatf("%s c%0d", name, i), {9'd0, obs_word}, {9'd0, exp_q.pop_front()});
      if (ncyc == 0 || i < n - 1) @(negedge clk);
    end
    exp_q.delete();
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = 6'h00;
    funct  = 6'h20;
    zero   = 1'b0;
    #3;
    exp_q.push_back(exp_word(4'd0, 6'h00, 1'b0, 1'b0));
    check_eq("reset", {9'd0, obs_word}, {9'd0, exp_q.pop_front()});
    @(negedge clk);
    rst_n = 1'b1;

    run_instr("lw",       6'h23, 6'h00, 1'b0, 0);
    run_instr("sw",       6'h2B, 6'h00, 1'b0, 0);
    run_instr("add",      6'h00, 6'h20, 1'b0, 0);
    run_instr("addi",     6'h08, 6'h00, 1'b0, 0);
    run_instr("ori",      6'h0D, 6'h00, 1'b0, 0);
    run_instr("beq_z1",   6'h04, 6'h00, 1'b1, 0);
    run_instr("beq_z0",   6'h04, 6'h00, 1'b0, 0);
    run_instr("bne_z1",   6'h05, 6'h00, 1'b1, 0);
    run_instr("bne_z0",   6'h05, 6'h00, 1'b0, 0);
    run_instr("j",        6'h02, 6'h00, 1'b0, 0);
    run_instr("jal",      6'h03, 6'h00, 1'b0, 0);
    run_instr("jr",       6'h00, 6'h08, 1'b0, 0);
    run_instr("ill_op",   6'h3F, 6'h00, 1'b0, 0);
    run_instr("add_sticky", 6'h00, 6'h22, 1'b0, 0);
    run_instr("ill_fn",   6'h00, 6'h3F, 1'b0, 0);
    run_instr("lw_sticky", 6'h23, 6'h00, 1'b1, 0);

    // Stop sw in MWR, then reset: mem_write and illegal drop at once.
    run_instr("sw_mwr",   6'h2B, 6'h00, 1'b0, 4);
    rst_n = 1'b0;
    #1;
    ill_exp = 1'b0;
    exp_q.push_back(exp_word(4'd0, 6'h2B, 1'b0, 1'b0));
    check_eq("reset_in_mwr", {9'd0, obs_word}, {9'd0, exp_q.pop_front()});
    @(negedge clk);
    rst_n = 1'b1;
    run_instr("or_after_rst", 6'h00, 6'h25, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
